i2c_target_rx: RTL
==================

Name: i2c_target_rx

Overview:
- Write-only I2C target (slave) receiver: the downstream consumer of the I2C master's scl_out/sda_out pins.
- Oversamples SCL/SDA on sys_clk and detects START, STOP and repeated START.
- Shifts in the address byte, ACKs its own 7-bit address for write transfers, then receives data bytes.
- Presents each received byte on a valid/ready handshake to the local logic behind it.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop stages in the SCL/SDA input synchronizers (minimum 2).

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  I2C clock pin, from the master's scl_out.
- sda_in  in  1  I2C data pin (resolved bus value), from the master's sda_out.
- sda_oe  out  1  1 = pull SDA low (open-drain ACK); 0 = release the line.
- rx_data  out  8  last received data byte; held stable until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_ready  in  1  downstream can accept a byte; sampled at ACK decision time.
- busy  out  1  1 from an address match until STOP or repeated START.
- rx_overrun  out  1  sticky; set when a byte is NACKed because rx_ready=0; cleared only by rst.

Behaviour:
- Reset values (rst=1 on a sys_clk edge, including mid-transfer): state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, busy=0, rx_overrun=0, bit counter=0, synchronizer flops=1.
- Input path:
  - scl_in and sda_in each pass through SYNC_STAGES flops, then one register for edge detect.
  - Event detection latency is SYNC_STAGES+1 sys_clk cycles after a pin change.
- Events, computed on the synchronized signals:
  - SCL_RISE, SCL_FALL.
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - SDA edges while SCL is low are data changes, not events.
- Bit sampling: SDA is sampled on SCL_RISE, MSB first, into an 8-bit shift register. The bit counter counts 0..7.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits on SCL_RISE. At the SCL_FALL after bit 7:
    - byte[7:1]==TARGET_ADDR and byte[0]==0 -> sda_oe=1, busy=1, go to ADDR_ACK.
    - otherwise (mismatch, or R/W=1) -> sda_oe=0, go to IGNORE.
  - ADDR_ACK: hold sda_oe=1 through the ACK clock. On the next SCL_FALL -> sda_oe=0, counter=0, go to DATA.
  - DATA: shift 8 bits. At the SCL_FALL after bit 7:
    - rx_ready=1 -> rx_data=byte, rx_valid=1 for exactly one cycle (the same edge), sda_oe=1, go to DATA_ACK.
    - rx_ready=0 -> no rx_valid, rx_overrun=1, sda_oe=0 (NACK), go to IGNORE.
  - DATA_ACK: on the next SCL_FALL -> sda_oe=0, counter=0, go to DATA. Back-to-back bytes are unlimited.
  - IGNORE: sda_oe=0; wait for START or STOP.
- STOP in any state -> IDLE, sda_oe=0, busy=0, counter=0. A partial byte is discarded with no rx_valid.
- START (repeated) in any state -> ADDR, counter=0, sda_oe=0, busy=0. A partial byte is discarded.
- Priority when several conditions hold in one cycle: rst > START/STOP > SCL_FALL > SCL_RISE.
- Master NACK/ACK during ACK clocks: sda_in is ignored in ACK states; the target never reads back the ACK bit.
- sda_oe is only ever changed on an SCL_FALL, START, STOP or rst. It must never change while synchronized SCL is high, except when forced low by STOP or START.

Test Plan:
- Write 0xA0 (addr 0x50, W), then 0x12, then STOP, rx_ready=1 -> sda_oe high during both ACK clocks; a single rx_valid pulse with rx_data=8'h12; busy 1 -> 0 after STOP; rx_overrun=0.
- Address 0xA2 (addr 0x51), then byte 0x34 -> sda_oe stays 0 throughout; no rx_valid; busy stays 0.
- Read request 0xA1 -> NACK (sda_oe=0); IGNORE until STOP; no rx_valid.
- Burst 0xA0, 0x01, 0x02, 0x03, then STOP -> three rx_valid pulses carrying 01, 02, 03 in order; three data ACKs.
- rx_ready=0 at the 2nd data byte of 0xA0, 0x11, 0x22 -> 0x11 is delivered; 0x22 is NACKed with no rx_valid; rx_overrun=1 and stays 1 after STOP.
- Two cases of mid-byte interruption:
  - Repeated START after 4 data bits, then 0xA0, 0x55 -> the partial byte is dropped, the address is re-ACKed, and rx_data=8'h55.
  - rst asserted mid-ADDR_ACK -> sda_oe=0 on the next cycle and all outputs return to their reset values.

Source files
------------

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: ACKs its own address on writes and
// hands each received data byte to local logic over valid/ready.
module i2c_target_rx #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       rx_overrun
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic [7:0]             shift_q;
   logic [2:0]             bit_cnt_q;
   logic                   full_q;
   logic                   sda_oe_q;
   logic [7:0]             rx_data_q;
   logic                   rx_valid_q;
   logic                   busy_q;
   logic                   overrun_q;

   logic scl_s;
   logic sda_s;
   logic scl_rise;
   logic scl_fall;
   logic start_ev;
   logic stop_ev;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   // SDA edges only count as bus conditions while SCL is stably high
   assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

   assign sda_oe     = sda_oe_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign busy       = busy_q;
   assign rx_overrun = overrun_q;

   // Pin synchronizers followed by one edge-detect register
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   // Protocol FSM: bus conditions override clocking, fall beats rise
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         full_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (start_ev) begin
            state_q   <= ADDR;
            bit_cnt_q <= 3'd0;
            full_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else if (stop_ev) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            full_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: ;
               ADDR, DATA: begin
                  if (scl_fall && full_q) begin
                     full_q <= 1'b0;
                     if (state_q == ADDR) begin
                        if (shift_q[7:1] == TARGET_ADDR && !shift_q[0]) begin
                           sda_oe_q <= 1'b1;
                           busy_q   <= 1'b1;
                           state_q  <= ADDR_ACK;
                        end else begin
                           sda_oe_q <= 1'b0;
                           state_q  <= IGNORE;
                        end
                     end else if (rx_ready) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                        sda_oe_q   <= 1'b1;
                        state_q    <= DATA_ACK;
                     end else begin
                        overrun_q <= 1'b1;
                        sda_oe_q  <= 1'b0;
                        state_q   <= IGNORE;
                     end
                  end else if (scl_rise && !full_q) begin
                     shift_q   <= {shift_q[6:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     full_q    <= (bit_cnt_q == 3'd7);
                  end
               end
               ADDR_ACK, DATA_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q  <= 1'b0;
                     bit_cnt_q <= 3'd0;
                     full_q    <= 1'b0;
                     state_q   <= DATA;
                  end
               end
               IGNORE: sda_oe_q <= 1'b0;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule
